// File: rtl/fill_valve_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fill_arb_pkg
// Shared definitions for the fill valve arbiter:
//   - FSM state encoding (IDLE / GRANT / SETTLE)
//   - default values for N_MACH, MAX_FILL and SETTLE_CYC
//   - clog2 helper, never returning less than 1 so that vectors sized
//     with it always have at least one bit
// -----------------------------------------------------------------------------
package fill_arb_pkg;

  localparam int DEF_N_MACH     = 4;
  localparam int DEF_MAX_FILL   = 8;
  localparam int DEF_SETTLE_CYC = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    SETTLE = 2'd2
  } arb_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fill_valve_arbiter_if.sv
// -----------------------------------------------------------------------------
// fill_valve_arbiter_if
// Bundle between the washing-machine controllers and the valve arbiter.
//   req      machines -> arbiter  per-machine water request (level)
//   rel      machines -> arbiter  per-machine "tank full" release pulse
//   gnt      arbiter -> machines  one-hot grant
//   owner    arbiter -> machines  index of current / last grantee
//   valve_on arbiter -> valve     inlet valve drive
//   busy     arbiter -> machines  arbiter in GRANT or SETTLE
//   to_flag  arbiter -> machines  sticky per-machine timeout flags
// Modports: master = machine side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface fill_valve_arbiter_if
  import fill_arb_pkg::*;
#(
  parameter int N_MACH = DEF_N_MACH
) ();

  localparam int OW = clog2(N_MACH);

  logic [N_MACH-1:0] req;
  logic [N_MACH-1:0] rel;
  logic [N_MACH-1:0] gnt;
  logic [OW-1:0]     owner;
  logic              valve_on;
  logic              busy;
  logic [N_MACH-1:0] to_flag;

  modport master (
    output req,
    output rel,
    input  gnt,
    input  owner,
    input  valve_on,
    input  busy,
    input  to_flag
  );

  modport slave (
    input  req,
    input  rel,
    output gnt,
    output owner,
    output valve_on,
    output busy,
    output to_flag
  );

endinterface

// File: rtl/fill_valve_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: finds the first set bit of elig searching
// upward from ptr and wrapping from N-1 back to 0.
//   elig    in   N   candidate vector
//   ptr     in   IW  search start index (must be < N)
//   valid   out  1   at least one candidate present
//   idx     out  IW  index of the chosen candidate
//   onehot  out  N   one-hot of idx, zero when nothing is eligible
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);

  // pos_w[gi] is the machine index visited at search offset gi.
  logic [IW:0]   sum_w [N];
  logic [IW-1:0] pos_w [N];
  logic [N-1:0]  hit_w;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_offset
      assign sum_w[gi] = {1'b0, ptr} + (IW+1)'(gi);
      assign pos_w[gi] = (sum_w[gi] >= (IW+1)'(N)) ? IW'(sum_w[gi] - (IW+1)'(N))
                                                   : IW'(sum_w[gi]);
      assign hit_w[gi] = elig[pos_w[gi]];
    end
  endgenerate

  // Scan from the largest offset down so the smallest hitting offset is
  // the one left standing.
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (hit_w[k]) begin
        idx = pos_w[k];
      end
    end
  end

  assign valid  = |elig;
  assign onehot = valid ? (N'(1) << idx) : '0;

endmodule

// File: rtl/fill_valve_arbiter.sv
// -----------------------------------------------------------------------------
// fill_valve_arbiter
// Shares one mains inlet valve among N_MACH washing machines. One machine at a
// time holds the grant (round-robin); each grant is cut off after MAX_FILL
// cycles and is followed by SETTLE_CYC valve-off cycles.
//   clk   in  system clock, rising edge
//   rst   in  asynchronous active-high reset
//   bus   slave modport of fill_valve_arbiter_if
//         (req, rel in; gnt, owner, valve_on, busy, to_flag out)
// -----------------------------------------------------------------------------
module fill_valve_arbiter
  import fill_arb_pkg::*;
#(
  parameter int N_MACH     = DEF_N_MACH,
  parameter int MAX_FILL   = DEF_MAX_FILL,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic                clk,
  input  logic                rst,
  fill_valve_arbiter_if.slave bus
);

  localparam int OW    = clog2(N_MACH);
  localparam int TW_F  = clog2(MAX_FILL);
  localparam int TW_S  = clog2(SETTLE_CYC);
  // One timer serves both GRANT and SETTLE, so it must hold either limit.
  localparam int TW    = (TW_F > TW_S) ? TW_F : TW_S;

  arb_state_t        state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [OW-1:0]     ptr_q, ptr_d;
  logic [N_MACH-1:0] gnt_q, gnt_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic              valve_on_q, valve_on_d;
  logic              busy_q, busy_d;
  logic [N_MACH-1:0] to_flag_q, to_flag_d;

  logic [N_MACH-1:0] elig;
  logic              pick_valid;
  logic [OW-1:0]     pick_idx;
  logic [N_MACH-1:0] pick_onehot;
  logic              owner_done;

  // Machines with a pending timeout are excluded until they drop req.
  assign elig = bus.req & ~to_flag_q;

  rr_pick #(
    .N  (N_MACH),
    .IW (OW)
  ) u_pick (
    .elig   (elig),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // Only the owner's rel/req bits can end a grant.
  assign owner_done = bus.rel[owner_q] | ~bus.req[owner_q];

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    valve_on_d = valve_on_q;
    busy_d     = busy_q;
    // Flags self-clear once the machine drops its request.
    to_flag_d  = to_flag_q & bus.req;

    case (state_q)
      IDLE: begin
        gnt_d      = '0;
        valve_on_d = 1'b0;
        busy_d     = 1'b0;
        if (pick_valid) begin
          gnt_d      = pick_onehot;
          owner_d    = pick_idx;
          valve_on_d = 1'b1;
          busy_d     = 1'b1;
          timer_d    = '0;
          state_d    = GRANT;
        end
      end

      GRANT: begin
        if (owner_done || (timer_q == TW'(MAX_FILL - 1))) begin
          // Release has priority over a timeout landing on the same edge.
          if (!owner_done) begin
            to_flag_d[owner_q] = 1'b1;
          end
          gnt_d      = '0;
          valve_on_d = 1'b0;
          busy_d     = 1'b1;
          ptr_d      = (owner_q == OW'(N_MACH - 1)) ? '0 : owner_q + OW'(1);
          timer_d    = '0;
          state_d    = SETTLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      SETTLE: begin
        gnt_d      = '0;
        valve_on_d = 1'b0;
        busy_d     = 1'b1;
        if (timer_q == TW'(SETTLE_CYC - 1)) begin
          timer_d = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: begin
        gnt_d      = '0;
        valve_on_d = 1'b0;
        busy_d     = 1'b0;
        timer_d    = '0;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      ptr_q      <= '0;
      gnt_q      <= '0;
      owner_q    <= '0;
      valve_on_q <= 1'b0;
      busy_q     <= 1'b0;
      to_flag_q  <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      valve_on_q <= valve_on_d;
      busy_q     <= busy_d;
      to_flag_q  <= to_flag_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.owner    = owner_q;
  assign bus.valve_on = valve_on_q;
  assign bus.busy     = busy_q;
  assign bus.to_flag  = to_flag_q;

endmodule

// File: tb/tb_fill_valve_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fill_valve_arbiter
// Directed bench for fill_valve_arbiter with N_MACH=4, MAX_FILL=8,
// SETTLE_CYC=2. Inputs change 1 time unit after a rising edge; outputs are
// sampled at the same point.
// -----------------------------------------------------------------------------
module tb_fill_valve_arbiter;
  import fill_arb_pkg::*;

  localparam int N  = 4;
  localparam int MF = 8;
  localparam int SC = 2;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  fill_valve_arbiter_if #(.N_MACH(N)) bus ();

  fill_valve_arbiter #(
    .N_MACH     (N),
    .MAX_FILL   (MF),
    .SETTLE_CYC (SC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus.busy !== 1'b0 || bus.gnt !== 4'b0000) && n < 40) begin
      tick();
      n++;
    end
    n_checks++;
    if (n >= 40) begin
      $display("FAIL wait_idle: busy=%b gnt=%b, required busy=0 gnt=0000 within 40 cycles", bus.busy, bus.gnt);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    bus.req = '0;
    bus.rel = '0;
    tick();
    tick();
    n_checks++; if (bus.gnt !== 4'b0000) begin $display("FAIL reset_gnt: got %b, required 0000", bus.gnt); n_fail++; end
    n_checks++; if (bus.valve_on !== 1'b0) begin $display("FAIL reset_valve: got %b, required 0", bus.valve_on); n_fail++; end
    n_checks++; if (bus.busy !== 1'b0) begin $display("FAIL reset_busy: got %b, required 0", bus.busy); n_fail++; end
    n_checks++; if (bus.owner !== 2'd0) begin $display("FAIL reset_owner: got %0d, required 0", bus.owner); n_fail++; end
    n_checks++; if (bus.to_flag !== 4'b0000) begin $display("FAIL reset_to_flag: got %b, required 0000", bus.to_flag); n_fail++; end
    rst = 1'b0;
    tick();
    $display("reset: gnt=%b valve=%b busy=%b owner=%0d", bus.gnt, bus.valve_on, bus.busy, bus.owner);
  endtask

  task automatic test_single_release();
    bus.req = 4'b0010;
    tick();
    n_checks++; if (bus.owner !== 2'd1) begin $display("FAIL single_owner: got %0d, required 1", bus.owner); n_fail++; end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.gnt !== 4'b0010) begin $display("FAIL single_gnt cycle %0d: got %b, required 0010", i, bus.gnt); n_fail++; end
      n_checks++; if (bus.valve_on !== 1'b1) begin $display("FAIL single_valve cycle %0d: got %b, required 1", i, bus.valve_on); n_fail++; end
      if (i == 3) bus.rel = 4'b0010;
      tick();
    end
    bus.rel = '0;
    bus.req = '0;
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b1) begin $display("FAIL single_settle cycle %0d: gnt=%b busy=%b, required gnt=0000 busy=1", i, bus.gnt, bus.busy); n_fail++; end
      tick();
    end
    n_checks++; if (bus.busy !== 1'b0) begin $display("FAIL single_idle_busy: got %b, required 0", bus.busy); n_fail++; end
    n_checks++; if (bus.to_flag !== 4'b0000) begin $display("FAIL single_to_flag: got %b, required 0000", bus.to_flag); n_fail++; end
    $display("single: 4-cycle grant to machine 1 with release, owner=%0d", bus.owner);
  endtask

  task automatic test_round_robin();
    rst     = 1'b1;
    bus.req = '0;
    bus.rel = '0;
    tick();
    rst     = 1'b0;
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      int       gap;
      logic [3:0] exp_g;
      gap   = 0;
      exp_g = 4'b0001 << (g % 4);
      while (bus.gnt === 4'b0000 && gap < 20) begin
        tick();
        gap++;
      end
      n_checks++; if (bus.gnt !== exp_g) begin $display("FAIL rr_gnt #%0d: got %b, required %b", g, bus.gnt, exp_g); n_fail++; end
      n_checks++; if (bus.owner !== 2'(g % 4)) begin $display("FAIL rr_owner #%0d: got %0d, required %0d", g, bus.owner, g % 4); n_fail++; end
      if (g > 0) begin
        n_checks++; if (gap != 3) begin $display("FAIL rr_gap #%0d: got %0d, required 3", g, gap); n_fail++; end
      end
      $display("rr: grant #%0d gnt=%b owner=%0d gap=%0d", g, bus.gnt, bus.owner, gap);
      bus.rel = exp_g;
      if (g == 4) bus.req = '0;
      tick();
      bus.rel = '0;
      n_checks++; if (bus.gnt !== 4'b0000 || bus.valve_on !== 1'b0) begin $display("FAIL rr_release #%0d: gnt=%b valve=%b, required 0000/0", g, bus.gnt, bus.valve_on); n_fail++; end
    end
    wait_idle();
  endtask

  task automatic test_timeout();
    int   hi;
    logic seen;
    bus.req = 4'b0100;
    tick();
    hi = 0;
    while (bus.gnt === 4'b0100 && hi < 20) begin
      hi++;
      tick();
    end
    n_checks++; if (hi != MF) begin $display("FAIL timeout_len: got %0d cycles, required %0d", hi, MF); n_fail++; end
    n_checks++; if (bus.to_flag !== 4'b0100) begin $display("FAIL timeout_flag: got %b, required 0100", bus.to_flag); n_fail++; end
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (bus.gnt !== 4'b0000) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin $display("FAIL timeout_regrant: got a grant, required none while flagged"); n_fail++; end
    n_checks++; if (bus.to_flag !== 4'b0100) begin $display("FAIL timeout_sticky: got %b, required 0100", bus.to_flag); n_fail++; end
    bus.req = 4'b0000;
    tick();
    n_checks++; if (bus.to_flag !== 4'b0000) begin $display("FAIL timeout_clear: got %b, required 0000", bus.to_flag); n_fail++; end
    bus.req = 4'b0100;
    tick();
    n_checks++; if (bus.gnt !== 4'b0100) begin $display("FAIL timeout_regrant_after_clear: got %b, required 0100", bus.gnt); n_fail++; end
    $display("timeout: grant length %0d, flag cleared, machine 2 regranted", hi);
    bus.req = 4'b0000;
    tick();
    wait_idle();
  endtask

  task automatic test_rel_timeout();
    bus.req = 4'b0001;
    tick();
    repeat (7) tick();
    n_checks++; if (bus.gnt !== 4'b0001) begin $display("FAIL reltmo_hold: got %b, required 0001", bus.gnt); n_fail++; end
    bus.rel = 4'b0001;
    tick();
    bus.rel = '0;
    n_checks++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b1) begin $display("FAIL reltmo_end: gnt=%b busy=%b, required 0000/1", bus.gnt, bus.busy); n_fail++; end
    n_checks++; if (bus.to_flag !== 4'b0000) begin $display("FAIL reltmo_flag: got %b, required 0000", bus.to_flag); n_fail++; end
    $display("rel+timeout: release on last cycle, to_flag=%b", bus.to_flag);
    bus.req = '0;
    wait_idle();
  endtask

  task automatic test_nonowner_settle();
    bus.req = 4'b0001;
    tick();
    n_checks++; if (bus.gnt !== 4'b0001) begin $display("FAIL nonowner_grant: got %b, required 0001", bus.gnt); n_fail++; end
    bus.rel = 4'b1000;
    tick();
    bus.rel = '0;
    n_checks++; if (bus.gnt !== 4'b0001) begin $display("FAIL nonowner_rel: got %b, required 0001", bus.gnt); n_fail++; end
    bus.rel = 4'b0001;
    tick();
    bus.rel = '0;
    bus.req = 4'b0010;
    n_checks++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b1) begin $display("FAIL settle0: gnt=%b busy=%b, required 0000/1", bus.gnt, bus.busy); n_fail++; end
    tick();
    n_checks++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b1) begin $display("FAIL settle1: gnt=%b busy=%b, required 0000/1", bus.gnt, bus.busy); n_fail++; end
    tick();
    n_checks++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin $display("FAIL settle_end: gnt=%b busy=%b, required 0000/0", bus.gnt, bus.busy); n_fail++; end
    tick();
    n_checks++; if (bus.gnt !== 4'b0010) begin $display("FAIL settle_arrival: got %b, required 0010", bus.gnt); n_fail++; end
    n_checks++; if (bus.owner !== 2'd1) begin $display("FAIL settle_owner: got %0d, required 1", bus.owner); n_fail++; end
    $display("nonowner/settle: rel[3] ignored, machine 1 granted after settle");
    bus.req = '0;
    tick();
    wait_idle();
  endtask

  task automatic test_reset_mid_grant();
    bus.req = 4'b0100;
    tick();
    n_checks++; if (bus.gnt !== 4'b0100) begin $display("FAIL midrst_grant: got %b, required 0100", bus.gnt); n_fail++; end
    tick();
    #3;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.gnt !== 4'b0000) begin $display("FAIL midrst_gnt: got %b, required 0000", bus.gnt); n_fail++; end
    n_checks++; if (bus.valve_on !== 1'b0) begin $display("FAIL midrst_valve: got %b, required 0", bus.valve_on); n_fail++; end
    n_checks++; if (bus.owner !== 2'd0 || bus.busy !== 1'b0) begin $display("FAIL midrst_state: owner=%0d busy=%b, required 0/0", bus.owner, bus.busy); n_fail++; end
    bus.req = 4'b0110;
    tick();
    rst = 1'b0;
    tick();
    n_checks++; if (bus.gnt !== 4'b0010) begin $display("FAIL midrst_first: got %b, required 0010", bus.gnt); n_fail++; end
    $display("reset mid-grant: first grant after reset gnt=%b", bus.gnt);
    bus.req = '0;
    tick();
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single_release();
    test_round_robin();
    test_timeout();
    test_rel_timeout();
    test_nonowner_settle();
    test_reset_mid_grant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fill_valve_arbiter.md
Name: fill_valve_arbiter

Overview:
- Shares one mains water inlet valve between N_MACH washing-machine controllers. Only one machine may be in its Fill stage drawing water at a time.
- Each machine raises req while it needs water. The arbiter grants one machine at a time, round-robin.
- Each grant is bounded by a fill timeout. A settle gap follows every grant so valve pressure can recover.
- Sits between the per-machine washing FSMs and the single valve driver. A machine's Fill stage advances only while it holds gnt.

Parameters:
- N_MACH, 4: number of requesting machines (2..8).
- MAX_FILL, 8: maximum grant length in clock cycles (2..255).
- SETTLE_CYC, 2: valve-off gap after each grant, in cycles (1..15).

Ports:
- clk  in  1  system clock, rising-edge active.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_MACH  per-machine water request; level, held high while filling.
- rel  in  N_MACH  per-machine release pulse ("tank full"); only the current owner's bit is honoured.
- gnt  out  N_MACH  one-hot grant, registered.
- owner  out  clog2(N_MACH)  index of the current or last grantee, registered.
- valve_on  out  1  inlet valve drive; equals OR of gnt, registered.
- busy  out  1  high in GRANT or SETTLE.
- to_flag  out  N_MACH  sticky timeout flag per machine.

Behaviour:
- Reset (asynchronous, active-high; takes effect immediately, including mid-grant):
  - gnt=0, valve_on=0, busy=0, owner=0, to_flag=0.
  - Round-robin pointer ptr=0, timer=0, state=IDLE.
- Eligible set: elig = req & ~to_flag.
- FSM states: IDLE, GRANT, SETTLE.
- IDLE:
  - If elig≠0, pick the first set bit searching upward from ptr, wrapping at N_MACH-1→0.
  - At that edge: gnt=onehot(pick), owner=pick, valve_on=1, busy=1, timer=0, state→GRANT.
  - Latency is one cycle: req sampled high at edge k gives gnt high after edge k.
  - If elig=0, stay in IDLE with all outputs low except to_flag.
- GRANT:
  - timer increments each cycle. Its width is clog2(MAX_FILL) and it never wraps inside GRANT.
  - Exit conditions, evaluated at each edge in priority order:
    1. rel[owner]=1 or req[owner]=0: normal end, no flag.
    2. timer==MAX_FILL-1: timeout, set to_flag[owner].
  - On exit: gnt=0, valve_on=0, ptr=(owner+1) mod N_MACH, timer=0, state→SETTLE.
  - Result: a timed-out grant lasts exactly MAX_FILL cycles.
  - rel on the same edge as the timeout: rel wins, no flag.
  - rel bits of non-owners are ignored in every state.
- SETTLE:
  - busy=1, gnt=0. timer counts up to SETTLE_CYC-1, then state→IDLE.
  - Requests arriving during SETTLE are not granted. They are served from IDLE one cycle after SETTLE ends.
  - Minimum spacing between two grants is therefore SETTLE_CYC+1 idle-valve cycles.
- to_flag[i]:
  - Set only on a timeout of machine i.
  - Cleared on the first edge where req[i]=0 (machine acknowledges the fault by dropping its request).
  - A set flag excludes machine i from arbitration.
- Invariants:
  - gnt is always one-hot or zero.
  - valve_on == |gnt.
  - gnt≠0 only in GRANT.
- Fairness: with all requests held high, grants rotate 0,1,2,3,0,…, so no machine waits more than N_MACH-1 grants.

Decomposition:
- Package fill_arb_pkg holds:
  - state encoding constants IDLE=2'd0, GRANT=2'd1, SETTLE=2'd2;
  - default values of N_MACH, MAX_FILL and SETTLE_CYC;
  - the clog2 helper function.
- One sub-module: rr_pick.
  - Purely combinational round-robin priority picker.
  - Inputs: elig[N], ptr. Outputs: valid, idx, onehot.
  - Keeps the top level to the FSM, timer and flag registers.

Test Plan:
- Reset mid-grant: machine 2 granted, assert rst mid-cycle → gnt=0 and valve_on=0 immediately (before the next edge); after release, the first grant goes to the lowest eligible machine searching from index 0.
- Single request with release: req=4'b0010, rel[1] pulse at grant cycle 3 → gnt=4'b0010 for 4 cycles, then SETTLE for 2 cycles, owner=1, to_flag=0.
- Round-robin: req=4'b1111 held, every owner releases after 1 cycle → grant order 0,1,2,3,0 with 3-cycle valve-off gaps.
- Timeout: req=4'b0100 held, no rel → gnt[2] high for exactly 8 cycles, then to_flag[2]=1 and machine 2 is not re-granted. Dropping req[2] for one cycle clears to_flag[2].
- Simultaneous rel and timeout: rel[owner] on the cycle where timer=7 → normal end, to_flag stays 0.
- Non-owner release and SETTLE arrival: rel[3] pulsed while machine 0 owns → ignored; req[1] rising during SETTLE → gnt[1] asserts exactly one cycle after SETTLE ends.
